// File: rtl/axi_vga_pkg.sv
// Shared types for the VGA frame sequencer: sequencer states and drain targets.
package axi_vga_pkg;

  typedef enum logic [1:0] {
    FC_OFF   = 2'd0,
    FC_RUN   = 2'd1,
    FC_DRAIN = 2'd2
  } frame_ctrl_state_e;

  typedef enum logic {
    DT_OFF  = 1'b0,
    DT_SWAP = 1'b1
  } drain_target_e;

endpackage

// File: rtl/axi_vga_ot_cnt.sv
// Saturating outstanding AR-burst counter with a zero flag, plus its checker.
module axi_vga_ot_cnt_chk #(
  parameter int unsigned MaxOutstanding = 8
) (
  input logic                                   clk_i,
  input logic                                   rst_i,
  input logic                                   inc_i,
  input logic                                   dec_i,
  input logic [$clog2(MaxOutstanding+1)-1:0]    cnt_i
);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && (cnt_i == '0)));
  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc_i && !dec_i && (cnt_i == CntMax)));
endmodule

module axi_vga_ot_cnt #(
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o
);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Illegal steps hold the count; the checker flags them.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

  axi_vga_ot_cnt_chk #(.MaxOutstanding(MaxOutstanding)) u_chk (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (inc_i),
    .dec_i (dec_i),
    .cnt_i (cnt_q)
  );
endmodule

// File: rtl/axi_vga_frame_ctrl.sv
// Frame sequencer: owns the pixel fetcher's enable and configuration, performs
// tear-free buffer swaps at frame boundaries and drains AXI bursts before restarts.
module axi_vga_frame_ctrl
  import axi_vga_pkg::*;
#(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned MinOffCycles   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_enable_i,
  input  logic [AddrWidth-1:0] cfg_base_addr_i,
  input  logic [31:0]          cfg_frame_size_i,
  input  logic [7:0]           cfg_burst_len_i,
  input  logic                 swap_valid_i,
  output logic                 swap_ready_o,
  input  logic [AddrWidth-1:0] swap_addr_i,
  input  logic                 frame_end_i,
  input  logic                 ar_hs_i,
  input  logic                 r_last_hs_i,
  output logic                 fetch_enable_o,
  output logic [AddrWidth-1:0] fetch_start_addr_o,
  output logic [31:0]          fetch_frame_size_o,
  output logic [7:0]           fetch_burst_len_o,
  output logic                 swap_done_o,
  output logic [31:0]          frame_cnt_o
);
  localparam int unsigned OffW = $clog2(MinOffCycles + 1);
  localparam logic [OffW-1:0] OffLast = OffW'(MinOffCycles - 1);

  frame_ctrl_state_e    state_q, state_d;
  drain_target_e        target_q, target_d;
  logic [OffW-1:0]      off_cnt_q, off_cnt_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [AddrWidth-1:0] pend_addr_q, pend_addr_d;
  logic                 en_q, en_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [31:0]          size_q, size_d;
  logic [7:0]           burst_q, burst_d;
  logic                 done_q, done_d;
  logic [31:0]          frame_cnt_q, frame_cnt_d;
  logic                 ot_zero;

  axi_vga_ot_cnt #(.MaxOutstanding(MaxOutstanding)) u_ot_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (ar_hs_i),
    .dec_i  (r_last_hs_i),
    .zero_o (ot_zero)
  );

  // Next-state, pending-slot and registered fetcher configuration.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    off_cnt_d   = off_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    en_d        = en_q;
    addr_d      = addr_q;
    size_d      = size_q;
    burst_d     = burst_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (swap_valid_i && !pend_vld_q) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = swap_addr_i;
    end else begin
      pend_addr_d = pend_addr_q;
    end

    case (state_q)
      FC_OFF: begin
        en_d    = 1'b0;
        addr_d  = cfg_base_addr_i;
        size_d  = cfg_frame_size_i;
        burst_d = cfg_burst_len_i;
        if (cfg_enable_i && ot_zero) begin
          state_d = FC_RUN;
          en_d    = 1'b1;
        end else begin
          state_d = FC_OFF;
        end
      end
      FC_RUN: begin
        en_d = 1'b1;
        if (frame_end_i) frame_cnt_d = frame_cnt_q + 32'd1;
        else             frame_cnt_d = frame_cnt_q;
        // Disable wins over a swap landing on the same boundary.
        if (!cfg_enable_i) begin
          state_d   = FC_DRAIN;
          target_d  = DT_OFF;
          off_cnt_d = '0;
          en_d      = 1'b0;
        end else if (frame_end_i && pend_vld_q) begin
          state_d    = FC_DRAIN;
          target_d   = DT_SWAP;
          off_cnt_d  = '0;
          en_d       = 1'b0;
          addr_d     = pend_addr_q;
          pend_vld_d = 1'b0;
          size_d     = cfg_frame_size_i;
          burst_d    = cfg_burst_len_i;
        end else begin
          state_d = FC_RUN;
        end
      end
      FC_DRAIN: begin
        en_d = 1'b0;
        if ((off_cnt_q >= OffLast) && ot_zero) begin
          if ((target_q == DT_SWAP) && cfg_enable_i) begin
            state_d = FC_RUN;
            en_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = FC_OFF;
          end
        end else if (off_cnt_q < OffLast) begin
          off_cnt_d = off_cnt_q + OffW'(1);
        end else begin
          off_cnt_d = off_cnt_q;
        end
      end
      default: begin
        state_d = FC_OFF;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FC_OFF;
      target_q    <= DT_OFF;
      off_cnt_q   <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      en_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= 32'd0;
      burst_q     <= 8'd0;
      done_q      <= 1'b0;
      frame_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      off_cnt_q   <= off_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign swap_ready_o       = !pend_vld_q;
  assign fetch_enable_o     = en_q;
  assign fetch_start_addr_o = addr_q;
  assign fetch_frame_size_o = size_q;
  assign fetch_burst_len_o  = burst_q;
  assign swap_done_o        = done_q;
  assign frame_cnt_o        = frame_cnt_q;
endmodule

// File: tb/tb_axi_vga_frame_ctrl.sv
// Bench for axi_vga_frame_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_axi_vga_frame_ctrl;
  localparam int unsigned AW     = 64;
  localparam int unsigned MaxOut = 8;
  localparam int unsigned MinOff = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, cfg_enable_i, swap_valid_i, frame_end_i, ar_hs_i, r_last_hs_i;
  logic [AW-1:0] cfg_base_addr_i, swap_addr_i;
  logic [31:0]   cfg_frame_size_i;
  logic [7:0]    cfg_burst_len_i;
  logic          swap_ready_o, fetch_enable_o, swap_done_o;
  logic [AW-1:0] fetch_start_addr_o;
  logic [31:0]   fetch_frame_size_o, frame_cnt_o;
  logic [7:0]    fetch_burst_len_o;

  axi_vga_frame_ctrl #(.AddrWidth(AW), .MaxOutstanding(MaxOut), .MinOffCycles(MinOff)) dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_enable_i(cfg_enable_i),
    .cfg_base_addr_i(cfg_base_addr_i), .cfg_frame_size_i(cfg_frame_size_i),
    .cfg_burst_len_i(cfg_burst_len_i), .swap_valid_i(swap_valid_i),
    .swap_ready_o(swap_ready_o), .swap_addr_i(swap_addr_i), .frame_end_i(frame_end_i),
    .ar_hs_i(ar_hs_i), .r_last_hs_i(r_last_hs_i), .fetch_enable_o(fetch_enable_o),
    .fetch_start_addr_o(fetch_start_addr_o), .fetch_frame_size_o(fetch_frame_size_o),
    .fetch_burst_len_o(fetch_burst_len_o), .swap_done_o(swap_done_o),
    .frame_cnt_o(frame_cnt_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Behavioural model: mode 0 = display off, 1 = scanning, 2 = waiting for the bus to go quiet.
  int            m_mode = 0;
  int            m_age = 0;
  int            m_out = 0;
  bit            m_to_swap = 1'b0;
  bit            m_pend = 1'b0;
  logic [AW-1:0] m_pend_addr = '0;
  logic          exp_en = 1'b0, exp_ready = 1'b1, exp_done = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [31:0]   exp_size = 32'd0, exp_fcnt = 32'd0;
  logic [7:0]    exp_burst = 8'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_step();
    int mode_n;
    bit pend_cur;
    if (rst_i) begin
      m_mode = 0; m_age = 0; m_out = 0; m_to_swap = 1'b0; m_pend = 1'b0;
      exp_en = 1'b0; exp_ready = 1'b1; exp_done = 1'b0; exp_addr = '0;
      exp_size = 32'd0; exp_burst = 8'd0; exp_fcnt = 32'd0;
      return;
    end
    mode_n   = m_mode;
    pend_cur = m_pend;
    exp_done = 1'b0;
    if (m_mode == 0) begin
      exp_addr = cfg_base_addr_i; exp_size = cfg_frame_size_i; exp_burst = cfg_burst_len_i;
      if (cfg_enable_i && m_out == 0) begin mode_n = 1; exp_en = 1'b1; end
    end else if (m_mode == 1) begin
      if (frame_end_i) exp_fcnt = exp_fcnt + 32'd1;
      if (!cfg_enable_i || (frame_end_i && pend_cur)) begin
        mode_n = 2; m_age = 0; exp_en = 1'b0;
        m_to_swap = cfg_enable_i;
        if (cfg_enable_i) begin
          exp_addr = m_pend_addr; m_pend = 1'b0;
          exp_size = cfg_frame_size_i; exp_burst = cfg_burst_len_i;
        end
      end
    end else begin
      m_age++;
      if (m_age >= MinOff && m_out == 0) begin
        if (m_to_swap && cfg_enable_i) begin mode_n = 1; exp_en = 1'b1; exp_done = 1'b1; end
        else mode_n = 0;
      end
    end
    if (swap_valid_i && !pend_cur) begin m_pend = 1'b1; m_pend_addr = swap_addr_i; end
    exp_ready = !m_pend;
    m_out = m_out + int'(ar_hs_i) - int'(r_last_hs_i);
    m_mode = mode_n;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_enable(input string nm);
    for (int i = 0; i < 12 && fetch_enable_o !== 1'b1; i++) tick();
    chk(nm, fetch_enable_o, 1'b1);
  endtask

  // Per-cycle comparison against the model, just after each active edge.
  always @(posedge clk) begin
    #1;
    if (check_en) begin
      chk("m_enable", fetch_enable_o, exp_en);
      chk("m_addr", fetch_start_addr_o, exp_addr);
      chk("m_size", fetch_frame_size_o, exp_size);
      chk("m_burst", fetch_burst_len_o, exp_burst);
      chk("m_ready", swap_ready_o, exp_ready);
      chk("m_done", swap_done_o, exp_done);
      chk("m_fcnt", frame_cnt_o, exp_fcnt);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_done;
    rst_i = 1'b1; cfg_enable_i = 1'b0; swap_valid_i = 1'b0; frame_end_i = 1'b0;
    ar_hs_i = 1'b0; r_last_hs_i = 1'b0; cfg_base_addr_i = '0; swap_addr_i = '0;
    cfg_frame_size_i = 32'd0; cfg_burst_len_i = 8'd0;
    tick();
    check_en = 1'b1;
    chk("rst_enable", fetch_enable_o, 1'b0);
    chk("rst_ready", swap_ready_o, 1'b1);
    chk("rst_fcnt", frame_cnt_o, 32'd0);

    // Enable from reset.
    rst_i = 1'b0; cfg_enable_i = 1'b1; cfg_base_addr_i = 64'h8000_0000;
    cfg_frame_size_i = 32'h0004_B000; cfg_burst_len_i = 8'd15;
    tick();
    chk("en_rise", fetch_enable_o, 1'b1);
    chk("en_addr", fetch_start_addr_o, 64'h8000_0000);
    chk("en_size", fetch_frame_size_o, 32'h0004_B000);
    chk("en_burst", fetch_burst_len_o, 8'd15);
    for (int i = 0; i < 3; i++) begin
      frame_end_i = 1'b1; tick(); frame_end_i = 1'b0; tick();
    end
    chk("fcnt_3", frame_cnt_o, 32'd3);

    // Swap with two bursts in flight, second request while slot is full.
    ar_hs_i = 1'b1; tick(); tick(); ar_hs_i = 1'b0;
    swap_valid_i = 1'b1; swap_addr_i = 64'h8010_0000; tick();
    chk("slot_full", swap_ready_o, 1'b0);
    swap_addr_i = 64'h9000_0000; tick();
    chk("second_blocked", swap_ready_o, 1'b0);
    frame_end_i = 1'b1; tick(); frame_end_i = 1'b0;
    chk("swap_en_low", fetch_enable_o, 1'b0);
    chk("swap_addr_early", fetch_start_addr_o, 64'h8010_0000);
    chk("ready_back", swap_ready_o, 1'b1);
    tick(); swap_valid_i = 1'b0;
    chk("second_accepted", swap_ready_o, 1'b0);
    tick();
    chk("en_low_inflight", fetch_enable_o, 1'b0);
    r_last_hs_i = 1'b1; tick(); tick(); r_last_hs_i = 1'b0;
    chk("en_low_until_rlast", fetch_enable_o, 1'b0);
    wait_enable("swap_en_back");
    chk("swap_done", swap_done_o, 1'b1);
    chk("swap_addr", fetch_start_addr_o, 64'h8010_0000);
    tick();
    chk("swap_done_once", swap_done_o, 1'b0);

    // Consume the queued 0x9000_0000 swap, then swap request on a boundary.
    frame_end_i = 1'b1; tick(); frame_end_i = 1'b0;
    wait_enable("swap2_en_back");
    chk("swap2_addr", fetch_start_addr_o, 64'h9000_0000);
    swap_valid_i = 1'b1; swap_addr_i = 64'h8020_0000; frame_end_i = 1'b1; tick();
    swap_valid_i = 1'b0; frame_end_i = 1'b0;
    chk("same_cycle_no_drain", fetch_enable_o, 1'b1);
    tick(); tick();
    frame_end_i = 1'b1; tick(); frame_end_i = 1'b0;
    chk("same_cycle_later_drain", fetch_enable_o, 1'b0);
    chk("same_cycle_later_addr", fetch_start_addr_o, 64'h8020_0000);
    wait_enable("swap3_en_back");
    chk("fcnt_7", frame_cnt_o, 32'd7);

    // Disable with a swap pending: drain to off, no done pulse.
    swap_valid_i = 1'b1; swap_addr_i = 64'hA000_0000; tick(); swap_valid_i = 1'b0;
    ar_hs_i = 1'b1; tick();
    r_last_hs_i = 1'b1; tick(); ar_hs_i = 1'b0; r_last_hs_i = 1'b0;
    cfg_enable_i = 1'b0; tick();
    chk("abort_en_low", fetch_enable_o, 1'b0);
    n_done = 0;
    r_last_hs_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); r_last_hs_i = 1'b0;
      if (swap_done_o === 1'b1) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    chk("abort_stays_off", fetch_enable_o, 1'b0);

    // Reset in the middle of a drain.
    cfg_enable_i = 1'b1; tick();
    chk("reen_en", fetch_enable_o, 1'b1);
    ar_hs_i = 1'b1; tick(); ar_hs_i = 1'b0;
    frame_end_i = 1'b1; tick(); frame_end_i = 1'b0; tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("mid_rst_en", fetch_enable_o, 1'b0);
    chk("mid_rst_addr", fetch_start_addr_o, 64'h0);
    chk("mid_rst_size", fetch_frame_size_o, 32'd0);
    chk("mid_rst_burst", fetch_burst_len_o, 8'd0);
    chk("mid_rst_ready", swap_ready_o, 1'b1);
    chk("mid_rst_done", swap_done_o, 1'b0);
    chk("mid_rst_fcnt", frame_cnt_o, 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst_i        = ($urandom_range(0, 299) == 0);
      cfg_enable_i = ($urandom_range(0, 99) < 96);
      frame_end_i  = ($urandom_range(0, 19) == 0);
      swap_valid_i = ($urandom_range(0, 3) == 0);
      swap_addr_i  = {$urandom, $urandom};
      if ($urandom_range(0, 49) == 0) begin
        cfg_base_addr_i  = {$urandom, $urandom};
        cfg_frame_size_i = $urandom;
        cfg_burst_len_i  = 8'($urandom_range(0, 255));
      end
      ar_hs_i     = exp_en && (m_out < int'(MaxOut)) && ($urandom_range(0, 2) == 0);
      r_last_hs_i = (m_out > 0) && ($urandom_range(0, 2) == 0);
      tick();
    end
    ar_hs_i = 1'b0; r_last_hs_i = 1'b0; rst_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_vga_frame_ctrl.md
# axi_vga_frame_ctrl

Frame sequencer that sits between the VGA register file and the pixel fetcher. It owns the fetcher's `enable` and its configuration inputs: start address, frame size and burst length. It performs tear-free double-buffer swaps at frame boundaries. Before any restart it drains in-flight AXI read bursts, so the fetcher always reloads cleanly.

## Interface
Parameters:
- `AddrWidth`, 64, width of framebuffer addresses.
- `MaxOutstanding`, 8, maximum AR bursts in flight; the outstanding counter is `$clog2(MaxOutstanding+1)` bits wide.
- `MinOffCycles`, 2, minimum number of cycles `fetch_enable_o` stays low per drain (at least 1).

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset. One clock; reset is synchronous and active-high.
- `cfg_enable_i`, input, 1: software display enable.
- `cfg_base_addr_i`, input, `AddrWidth`: buffer address used when enabling from OFF.
- `cfg_frame_size_i`, input, 32: frame size in bytes.
- `cfg_burst_len_i`, input, 8: AXI len value.
- `swap_valid_i`, input, 1: request to swap buffers.
- `swap_ready_o`, output, 1: swap request accepted.
- `swap_addr_i`, input, `AddrWidth`: address of the new buffer.
- `frame_end_i`, input, 1: one-cycle pulse from the timing FSM on the last pixel of a frame.
- `ar_hs_i`, input, 1: `ar_valid & ar_ready` on the fetcher's AXI port.
- `r_last_hs_i`, input, 1: `r_valid & r_ready & r.last` on the fetcher's AXI port.
- `fetch_enable_o`, output, 1: drives the fetcher's `enable_i`.
- `fetch_start_addr_o`, output, `AddrWidth`: drives the fetcher's start address.
- `fetch_frame_size_o`, output, 32: drives the fetcher's frame size.
- `fetch_burst_len_o`, output, 8: drives the fetcher's burst length.
- `swap_done_o`, output, 1: one-cycle pulse (interrupt source) when a swap completes.
- `frame_cnt_o`, output, 32: count of completed frames.

## Operation
- States are OFF, RUN and DRAIN. Per-state output:
  - `fetch_enable_o=1` only in RUN.
  - All `fetch_*` outputs are registered.
- Pending-swap buffer:
  - One pending slot, `pend_vld` plus `pend_addr`.
  - `swap_ready_o = !pend_vld`. A handshake loads the slot.
- Outstanding counter:
  - +1 on `ar_hs_i`, -1 on `r_last_hs_i`; both together leave it unchanged.
  - Decrement at 0 and increment at `MaxOutstanding` are assertion errors; the counter holds its value.
- OFF:
  - While here, shadow the config: `fetch_start_addr_o<=cfg_base_addr_i`, `fetch_frame_size_o<=cfg_frame_size_i`, `fetch_burst_len_o<=cfg_burst_len_i`.
  - If `cfg_enable_i` is high and the outstanding count is 0, go to RUN.
- RUN:
  - `frame_end_i` increments `frame_cnt_o` (wraps at 2^32).
  - `!cfg_enable_i` goes to DRAIN with target=OFF; this has priority over a swap.
  - `frame_end_i & pend_vld` goes to DRAIN with target=SWAP. On that transition:
    - `fetch_start_addr_o<=pend_addr` and the pending slot clears.
    - Frame size and burst length re-shadow from the `cfg_*` inputs.
- DRAIN:
  - An off-cycle counter runs from 0.
  - Leave when the counter has reached `MinOffCycles`-1 and the outstanding count is 0:
    - target=SWAP with `cfg_enable_i` high: go to RUN and pulse `swap_done_o` in the first RUN cycle.
    - Otherwise: go to OFF. An aborted swap still counts as consumed; `swap_done_o` does not fire.
- Simultaneous events:
  - A swap handshake in the same cycle as `frame_end_i` does not apply to that frame boundary; it waits for the next `frame_end_i`.
  - `cfg_*` changes while in RUN take effect only at the next restart.
- Synchronous reset mid-operation: the block enters OFF immediately, clears the pending slot and the outstanding counter, and drops enable.

## Timing
- Reset values: `fetch_enable_o=0`, `fetch_start_addr_o=0`, `fetch_frame_size_o=0`, `fetch_burst_len_o=0`, `swap_ready_o=1`, `swap_done_o=0`, `frame_cnt_o=0`.
- `frame_end_i` at cycle t in RUN with `pend_vld`:
  - `fetch_enable_o` is low at t+1.
  - The new address is visible at t+1.
  - Earliest `fetch_enable_o` high is t+1+`MinOffCycles`; `swap_done_o` pulses in that same cycle.
- The start address is stable for at least `MinOffCycles` cycles of enable-low before enable rises, because the fetcher samples it while disabled.
- `swap_ready_o` reasserts at t+1 after the slot is consumed.
- OFF to RUN: enable rises 1 cycle after the qualifying `cfg_enable_i`.

## Structure
- Package `axi_vga_pkg`:
  - `frame_ctrl_state_e` (OFF, RUN, DRAIN).
  - `drain_target_e` (OFF, SWAP).
- Sub-module `axi_vga_ot_cnt`: the saturating outstanding-burst up/down counter with a zero flag and error assertions.

## Test plan
- Enable from reset with base=0x8000_0000 and size=0x4B000:
  - Enable rises 1 cycle later.
  - The outputs equal the cfg values.
  - `frame_cnt_o` reaches 3 after 3 `frame_end_i` pulses.
- Swap to 0x8010_0000 with 2 bursts in flight at `frame_end_i`:
  - Enable stays low until both `r_last_hs_i` arrive, and for at least 2 cycles.
  - Then addr=0x8010_0000 and `swap_done_o` is high for exactly one cycle.
- Second `swap_valid_i` while the slot is full:
  - `swap_ready_o=0` and it is not accepted.
  - It is accepted 1 cycle after the next frame boundary.
- `swap_valid_i` and `frame_end_i` in the same cycle:
  - No drain occurs at that boundary.
  - The swap happens at the following `frame_end_i`.
- `cfg_enable_i` drops in RUN with a swap pending:
  - The block goes DRAIN then OFF.
  - `swap_done_o` never fires.
  - `ar_hs_i` and `r_last_hs_i` in the same cycle leave the counter unchanged.
- `rst_i` asserted mid-DRAIN: the next cycle shows all reset values, and `swap_ready_o=1`.
